// File: rtl/sobel_window_ctrl_if.sv
// Handshake and status bundle between the Sobel window controller and its environment.
// The controller uses the slave modport; whoever drives frames uses master.
interface sobel_window_ctrl_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        shift_en;
    logic        pos_valid;
    logic [11:0] a22_x;
    logic [11:0] a22_y;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, shift_en, pos_valid, a22_x, a22_y, busy, frame_done
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, shift_en, pos_valid, a22_x, a22_y, busy, frame_done
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for a 3x3 Sobel window: fills the line buffers, runs one
// centre per pixel, then flushes the padding border so every pixel gets a result.
module sobel_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    sobel_window_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [23:0] FILL_LEN   = 24'(IMG_W + 1);
    localparam logic [23:0] FRAME_LEN  = 24'(IMG_W * IMG_H);
    localparam logic [11:0] FLUSH_LAST = 12'(IMG_W);
    localparam logic [11:0] X_LAST     = 12'(IMG_W - 1);

    state_t      state_q, state_d;
    logic [23:0] in_cnt_q, in_cnt_d;
    logic [11:0] flush_cnt_q, flush_cnt_d;
    logic [11:0] a22_x_q, a22_x_d;
    logic [11:0] a22_y_q, a22_y_d;

    logic in_ready;
    logic shift_en;
    logic pos_valid;
    logic frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            flush_cnt_q <= '0;
            a22_x_q     <= '0;
            a22_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            a22_x_q     <= a22_x_d;
            a22_y_q     <= a22_y_d;
        end
    end

    // Stalls leave every counter untouched because updates happen only on shift_en.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        a22_x_d     = a22_x_q;
        a22_y_d     = a22_y_q;
        in_ready    = 1'b0;
        shift_en    = 1'b0;
        pos_valid   = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = FILL;
                    in_cnt_d    = '0;
                    flush_cnt_d = '0;
                    a22_x_d     = '0;
                    a22_y_d     = '0;
                end
            end
            FILL: begin
                in_ready = bus.out_ready;
                shift_en = bus.in_valid && in_ready;
                if (shift_en) begin
                    in_cnt_d = in_cnt_q + 24'd1;
                    if (in_cnt_q + 24'd1 == FILL_LEN) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                in_ready  = bus.out_ready;
                shift_en  = bus.in_valid && in_ready;
                pos_valid = shift_en;
                if (shift_en) begin
                    in_cnt_d = in_cnt_q + 24'd1;
                    if (in_cnt_q + 24'd1 == FRAME_LEN) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                shift_en  = bus.out_ready;
                pos_valid = shift_en;
                if (shift_en) begin
                    flush_cnt_d = flush_cnt_q + 12'd1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pos_valid) begin
            if (a22_x_q == X_LAST) begin
                a22_x_d = '0;
                a22_y_d = a22_y_q + 12'd1;
            end else begin
                a22_x_d = a22_x_q + 12'd1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.shift_en   = shift_en;
    assign bus.pos_valid  = pos_valid;
    assign bus.frame_done = frame_done;
    assign bus.a22_x      = a22_x_q;
    assign bus.a22_y      = a22_y_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 4x3 instance for the frame scenarios and a
// 2x2 instance for the minimum-size frame.
module tb_sobel_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sobel_window_ctrl_if ifa ();
    sobel_window_ctrl_if ifb ();

    sobel_window_ctrl #(.IMG_W(4), .IMG_H(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sobel_window_ctrl #(.IMG_W(2), .IMG_H(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Observations collected by run_frame for the 4x3 instance.
    int px[$];
    int py[$];
    int r_pulses, r_hs, r_first_pv_hs, r_viol, r_hold_viol, r_quiet;
    int r_done_cnt, r_done_gap, r_busy_after, r_timeout;

    task automatic run_frame(input int mode);
        int          cyc = 0;
        int          stall_left = 0;
        int          last_shift = -100;
        bit          s1 = 0;
        bit          s2 = 0;
        bit          finished = 0;
        bit          prev_pv = 0;
        logic [11:0] prev_x = '0;
        logic [11:0] prev_y = '0;
        px.delete();
        py.delete();
        r_pulses = 0; r_hs = 0; r_first_pv_hs = -1; r_viol = 0; r_hold_viol = 0;
        r_quiet = 0; r_done_cnt = 0; r_done_gap = -1; r_busy_after = -1; r_timeout = 0;
        while (!finished && cyc < 300) begin
            ifa.start = (cyc == 0) || (mode == 3);
            if (mode == 1 && r_pulses == 3 && !s1) begin s1 = 1; stall_left = 3; end
            if (mode == 1 && r_pulses == 9 && !s2) begin s2 = 1; stall_left = 3; end
            ifa.out_ready = (stall_left == 0);
            ifa.in_valid  = (mode == 2) ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            if (!ifa.out_ready) begin
                if (ifa.in_ready || ifa.shift_en || ifa.pos_valid) r_viol++;
                else r_quiet++;
            end
            if (ifa.pos_valid && !ifa.shift_en) r_viol++;
            if (mode == 2 && r_pulses < 7 && ifa.shift_en && !ifa.in_valid) r_viol++;
            if (cyc >= 2 && !prev_pv && (ifa.a22_x !== prev_x || ifa.a22_y !== prev_y))
                r_hold_viol++;
            if (ifa.shift_en && ifa.in_ready) begin
                r_hs++;
                if (ifa.pos_valid && r_first_pv_hs < 0) r_first_pv_hs = r_hs;
            end
            if (ifa.pos_valid) begin
                px.push_back(int'(ifa.a22_x));
                py.push_back(int'(ifa.a22_y));
                r_pulses++;
            end
            if (ifa.shift_en) last_shift = cyc;
            if (ifa.frame_done) begin
                r_done_cnt++;
                r_done_gap = cyc - last_shift;
                finished   = 1;
            end
            prev_pv = ifa.pos_valid;
            prev_x  = ifa.a22_x;
            prev_y  = ifa.a22_y;
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
            cyc++;
        end
        if (!finished) r_timeout = 1;
        ifa.start = (mode == 3);
        @(negedge clk);
        r_busy_after = int'(ifa.busy);
        if (ifa.frame_done) r_done_cnt++;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        ifb.start = 1'b0; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({ifa.in_ready, ifa.shift_en, ifa.pos_valid, ifa.busy, ifa.frame_done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_during outputs got %b want 00000",
                     {ifa.in_ready, ifa.shift_en, ifa.pos_valid, ifa.busy, ifa.frame_done});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.in_ready, ifa.shift_en, ifa.pos_valid, ifa.busy, ifa.frame_done} !== 5'b0 ||
            ifa.a22_x !== 12'd0 || ifa.a22_y !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_after got flags=%b x=%0d y=%0d want 00000 0 0",
                     {ifa.in_ready, ifa.shift_en, ifa.pos_valid, ifa.busy, ifa.frame_done},
                     ifa.a22_x, ifa.a22_y);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame;
        run_frame(0);
        checks++;
        if (r_timeout !== 0 || r_pulses !== 12) begin
            errors++;
            $display("[TB] FAIL basic_pulses got %0d (timeout %0d) want 12", r_pulses, r_timeout);
        end
        checks++;
        if (r_first_pv_hs !== 6 || r_hs !== 12) begin
            errors++;
            $display("[TB] FAIL basic_fill got first_pv_hs=%0d hs=%0d want 6 12", r_first_pv_hs, r_hs);
        end
        for (int i = 0; i < px.size() && i < 12; i++) begin
            checks++;
            if (px[i] !== i % 4 || py[i] !== i / 4) begin
                errors++;
                $display("[TB] FAIL basic_coord[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, px[i], py[i], i % 4, i / 4);
            end
        end
        checks++;
        if (r_done_cnt !== 1 || r_done_gap !== 1 || r_busy_after !== 0) begin
            errors++;
            $display("[TB] FAIL basic_done got cnt=%0d gap=%0d busy_after=%0d want 1 1 0",
                     r_done_cnt, r_done_gap, r_busy_after);
        end
        checks++;
        if (r_viol !== 0 || r_hold_viol !== 0) begin
            errors++;
            $display("[TB] FAIL basic_rules got viol=%0d hold=%0d want 0 0", r_viol, r_hold_viol);
        end
    endtask

    task automatic test_backpressure;
        run_frame(1);
        checks++;
        if (r_timeout !== 0 || r_pulses !== 12 || r_first_pv_hs !== 6) begin
            errors++;
            $display("[TB] FAIL bp_pulses got %0d first_pv_hs=%0d want 12 6", r_pulses, r_first_pv_hs);
        end
        for (int i = 0; i < px.size() && i < 12; i++) begin
            checks++;
            if (px[i] !== i % 4 || py[i] !== i / 4) begin
                errors++;
                $display("[TB] FAIL bp_coord[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, px[i], py[i], i % 4, i / 4);
            end
        end
        checks++;
        if (r_quiet !== 6 || r_viol !== 0 || r_hold_viol !== 0) begin
            errors++;
            $display("[TB] FAIL bp_stall got quiet=%0d viol=%0d hold=%0d want 6 0 0",
                     r_quiet, r_viol, r_hold_viol);
        end
        checks++;
        if (r_done_cnt !== 1 || r_done_gap !== 1 || r_busy_after !== 0) begin
            errors++;
            $display("[TB] FAIL bp_done got cnt=%0d gap=%0d busy_after=%0d want 1 1 0",
                     r_done_cnt, r_done_gap, r_busy_after);
        end
    endtask

    task automatic test_in_valid_toggle;
        run_frame(2);
        checks++;
        if (r_timeout !== 0 || r_pulses !== 12 || r_hs !== 12) begin
            errors++;
            $display("[TB] FAIL toggle_pulses got %0d hs=%0d want 12 12", r_pulses, r_hs);
        end
        for (int i = 0; i < px.size() && i < 12; i++) begin
            checks++;
            if (px[i] !== i % 4 || py[i] !== i / 4) begin
                errors++;
                $display("[TB] FAIL toggle_coord[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, px[i], py[i], i % 4, i / 4);
            end
        end
        checks++;
        if (r_viol !== 0 || r_hold_viol !== 0 || r_done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL toggle_rules got viol=%0d hold=%0d done=%0d want 0 0 1",
                     r_viol, r_hold_viol, r_done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame;
        int hs = 0;
        int cyc = 0;
        int done_seen = 0;
        ifa.in_valid = 1'b1;
        ifa.out_ready = 1'b1;
        while (hs < 8 && cyc < 100) begin
            ifa.start = (cyc == 0);
            @(negedge clk);
            if (ifa.shift_en && ifa.in_ready) hs++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (hs !== 8) begin
            errors++;
            $display("[TB] FAIL rstmid_reach got hs=%0d want 8", hs);
        end
        ifa.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.a22_x !== 12'd0 || ifa.a22_y !== 12'd0 || ifa.frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_after got busy=%b x=%0d y=%0d done=%b want 0 0 0 0",
                     ifa.busy, ifa.a22_x, ifa.a22_y, ifa.frame_done);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.frame_done || ifa.busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("[TB] FAIL rstmid_idle got active_cycles=%0d want 0", done_seen);
        end
        @(posedge clk);
        #1;
        run_frame(0);
        checks++;
        if (r_timeout !== 0 || r_pulses !== 12 || r_done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL rstmid_refill got pulses=%0d done=%0d want 12 1", r_pulses, r_done_cnt);
        end
        for (int i = 0; i < px.size() && i < 12; i++) begin
            checks++;
            if (px[i] !== i % 4 || py[i] !== i / 4) begin
                errors++;
                $display("[TB] FAIL rstmid_coord[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, px[i], py[i], i % 4, i / 4);
            end
        end
    endtask

    task automatic test_start_held;
        run_frame(3);
        checks++;
        if (r_timeout !== 0 || r_pulses !== 12 || r_done_cnt !== 1 || r_busy_after !== 0) begin
            errors++;
            $display("[TB] FAIL held_frame got pulses=%0d done=%0d busy_after=%0d want 12 1 0",
                     r_pulses, r_done_cnt, r_busy_after);
        end
        ifa.start = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_restart got busy=%b want 1", ifa.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_min_frame;
        int exp_x[4] = '{0, 1, 0, 1};
        int exp_y[4] = '{0, 0, 1, 1};
        int qx[$];
        int qy[$];
        int fill_hs = 0;
        int run_hs = 0;
        int done = 0;
        int cyc = 0;
        ifb.in_valid = 1'b1;
        ifb.out_ready = 1'b1;
        while (!done && cyc < 60) begin
            ifb.start = (cyc == 0);
            @(negedge clk);
            if (ifb.shift_en && ifb.in_ready && !ifb.pos_valid) fill_hs++;
            if (ifb.shift_en && ifb.in_ready && ifb.pos_valid) run_hs++;
            if (ifb.pos_valid) begin
                qx.push_back(int'(ifb.a22_x));
                qy.push_back(int'(ifb.a22_y));
            end
            if (ifb.frame_done) done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        ifb.start = 1'b0;
        checks++;
        if (fill_hs !== 3 || run_hs !== 1) begin
            errors++;
            $display("[TB] FAIL min_hs got fill=%0d run=%0d want 3 1", fill_hs, run_hs);
        end
        checks++;
        if (qx.size() !== 4 || done !== 1) begin
            errors++;
            $display("[TB] FAIL min_pulses got %0d done=%0d want 4 1", qx.size(), done);
        end
        for (int i = 0; i < qx.size() && i < 4; i++) begin
            checks++;
            if (qx[i] !== exp_x[i] || qy[i] !== exp_y[i]) begin
                errors++;
                $display("[TB] FAIL min_coord[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, qx[i], qy[i], exp_x[i], exp_y[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_in_valid_toggle();
        test_reset_mid_frame();
        test_start_held();
        test_min_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk rises sample all state; rst high at a rising clk edge resets the block.
REQ-002 Parameters SHALL be, one per line:
- IMG_W, default 640: pixels per line, range 2..4095.
- IMG_H, default 480: lines per frame, range 2..4095.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- in_valid  in  1  upstream pixel available.
- in_ready  out  1  block accepts an upstream pixel this cycle.
- out_ready  in  1  downstream can take one Sobel result this cycle.
- shift_en  out  1  advance line buffers, window and Sobel pipeline by one position.
- pos_valid  out  1  window centre for this shift is inside the image.
- a22_x  out  12  column of the window centre, valid with pos_valid.
- a22_y  out  12  row of the window centre, valid with pos_valid.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-004 The FSM SHALL have states IDLE, FILL, RUN, FLUSH and DONE. The state register is the only source of busy: busy = (state != IDLE).
REQ-005 IDLE->FILL SHALL occur when start=1; in_cnt, a22_x and a22_y clear on this transition. start in any other state SHALL be ignored.
REQ-006 In_ready SHALL be 1 only when the state is FILL or RUN and out_ready=1. A handshake occurs when in_valid && in_ready.
REQ-007 In FILL and RUN, shift_en SHALL equal in_valid && in_ready. In FLUSH, shift_en SHALL equal out_ready. In IDLE and DONE, shift_en SHALL be 0.
REQ-008 In_cnt SHALL be 24 bits wide and increment by one on each handshake.
REQ-009 FILL SHALL consume exactly IMG_W+1 pixels with pos_valid=0. FILL->RUN SHALL occur on the handshake that makes in_cnt = IMG_W+1.
REQ-010 RUN SHALL consume the remaining IMG_W*IMG_H-(IMG_W+1) pixels with pos_valid=shift_en. RUN->FLUSH SHALL occur on the handshake that makes in_cnt = IMG_W*IMG_H.
REQ-011 FLUSH SHALL issue exactly IMG_W+1 shifts with pos_valid=shift_en and consume no input. These shifts drain the padding border. A 12-bit flush counter counts them; FLUSH->DONE SHALL occur on the last one.
REQ-012 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-013 Pos_valid SHALL be 0 whenever shift_en=0. Stalls (in_valid=0 or out_ready=0) SHALL hold all counters, coordinates and state unchanged.
REQ-014 On every cycle with pos_valid=1, a22_x/a22_y SHALL present the current centre. Registered at that edge:
- if a22_x = IMG_W-1: a22_x goes to 0 and a22_y increments.
- otherwise a22_x increments.
REQ-015 Total pos_valid pulses per frame SHALL be exactly IMG_W*IMG_H, in raster order from (0,0) to (IMG_W-1, IMG_H-1).
REQ-016 Shift_en, pos_valid, in_ready and frame_done SHALL be combinational from state, counters and handshake inputs. A22_x/a22_y SHALL be registered.
REQ-017 When start=1 arrives in the same cycle frame_done is high, it SHALL be ignored; start is honoured from the next cycle (IDLE).

Reset
REQ-018 On rst=1, the state SHALL go to IDLE, and in_cnt, the flush counter, a22_x and a22_y SHALL go to 0.
REQ-019 During and directly after reset, in_ready, shift_en, pos_valid, busy and frame_done SHALL all be 0.
REQ-020 Rst asserted mid-frame, in any state, SHALL abort the frame with no frame_done pulse. A new frame then requires a fresh start.

Verification
REQ-021 Use IMG_W=4, IMG_H=3, in_valid=1 and out_ready=1 throughout, and pulse start. Required response:
- the first 5 handshakes give pos_valid=0;
- the 6th handshake gives pos_valid=1 at (0,0);
- 7 RUN pulses then 5 FLUSH pulses follow, 12 in total, ending at (3,2);
- frame_done is high on the cycle after the last flush shift;
- busy is 0 on the next cycle.
REQ-022 Same setup, with out_ready=0 for 3 cycles during RUN and again during FLUSH. Required response: in_ready=0, shift_en=0 and pos_valid=0 on those cycles; coordinates hold; the output sequence is identical to REQ-021.
REQ-023 In_valid toggled 1/0 every cycle. Required response: shifts occur only on in_valid=1 cycles; 12 pulses; the frame completes with correct coordinates.
REQ-024 Rst=1 for one cycle in RUN after the 8th handshake. Required response: the next cycle shows busy=0, a22_x=0, a22_y=0 and no frame_done. A following start gives a full, correct 12-pulse frame.
REQ-025 Start held at 1 for the whole frame. Required response: exactly one frame with 12 pulses. A second frame begins only after DONE returns to IDLE, with start honoured in IDLE.
REQ-026 IMG_W=2, IMG_H=2 (minimum). Required response: FILL consumes 3 pixels, RUN consumes 1 pixel with pos_valid (0,0), FLUSH gives 3 pulses (1,0), (0,1), (1,1), then frame_done.
